// File: rtl/multi_channel_sensor_interface.sv
// Time-slot sensor encoder: each channel emits one pulse per frame on a shared
// line. The slot position identifies the channel and the group index carries
// the latched value. Outputs are decoded from registered state only.
module multi_channel_sensor_interface #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SLOT_W = 4,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                     clk_division,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic                     continuous,
  input  logic [NUM_CH*DATA_W-1:0] sensor,
  input  logic [SLOT_W-1:0]        base_address,
  output logic                     slot,
  output logic                     busy,
  output logic                     frame_done
);

  typedef enum logic {StIdle, StSample} state_e;

  state_e                         state_q, state_d;
  logic [SLOT_W-1:0]              slot_counter_q, slot_counter_d;
  logic [DATA_W-1:0]              data_counter_q, data_counter_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  data_q, data_d;
  logic [SLOT_W-1:0]              base_q, base_d;

  logic              last_cycle;
  logic [NUM_CH-1:0] match;

  assign last_cycle = (&slot_counter_q) && (&data_counter_q);

  // State and datapath registers; asynchronous reset clears everything.
  always_ff @(posedge clk_division or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      slot_counter_q <= '0;
      data_counter_q <= '0;
      data_q         <= '0;
      base_q         <= '0;
    end else begin
      state_q        <= state_d;
      slot_counter_q <= slot_counter_d;
      data_counter_q <= data_counter_d;
      data_q         <= data_d;
      base_q         <= base_d;
    end
  end

  // Next-state: latch on frame start, count through the frame, and either
  // re-latch (continuous) or return to idle at the last frame cycle.
  always_comb begin
    state_d        = state_q;
    slot_counter_d = slot_counter_q;
    data_counter_d = data_counter_q;
    data_d         = data_q;
    base_d         = base_q;
    unique case (state_q)
      StIdle: begin
        if (sample_en) begin
          state_d        = StSample;
          slot_counter_d = '0;
          data_counter_d = '0;
          data_d         = sensor;
          base_d         = base_address;
        end
      end
      StSample: begin
        slot_counter_d = slot_counter_q + 1'b1;
        if (&slot_counter_q) begin
          data_counter_d = data_counter_q + 1'b1;
        end
        if (last_cycle) begin
          slot_counter_d = '0;
          data_counter_d = '0;
          if (continuous) begin
            // Back-to-back frame: no idle gap, fresh sample taken here.
            data_d = sensor;
            base_d = base_address;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Per-channel match; the slot add wraps at SLOT_W bits by comparison width.
  for (genvar g = 0; g < NUM_CH; g++) begin : gen_match
    logic [SLOT_W-1:0] ch_slot;
    assign ch_slot  = base_q + SLOT_W'(g);
    assign match[g] = (state_q == StSample) && (slot_counter_q == ch_slot) &&
                      (data_counter_q == data_q[g]);
  end

  assign slot       = |match;
  assign busy       = (state_q == StSample);
  assign frame_done = (state_q == StSample) && last_cycle;

endmodule

// File: tb/tb_multi_channel_sensor_interface.sv
// Directed bench: default-parameter instance for frame timing, continuous mode,
// ignored restart and async reset; a small instance for a 4-channel config.
module tb_multi_channel_sensor_interface;

  logic        clk_division = 1'b0;
  logic        rst;
  logic        sample_en, continuous;
  logic [15:0] sensor;
  logic [3:0]  base_address;
  logic        slot, busy, frame_done;

  logic        sample_en2, continuous2;
  logic [11:0] sensor2;
  logic [1:0]  base_address2;
  logic        slot2, busy2, frame_done2;

  int checks = 0;
  int errors = 0;

  always #5 clk_division = ~clk_division;

  multi_channel_sensor_interface dut (
    .clk_division (clk_division),
    .rst          (rst),
    .sample_en    (sample_en),
    .continuous   (continuous),
    .sensor       (sensor),
    .base_address (base_address),
    .slot         (slot),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  multi_channel_sensor_interface #(
    .DATA_W (3),
    .SLOT_W (2),
    .NUM_CH (4)
  ) dut_small (
    .clk_division (clk_division),
    .rst          (rst),
    .sample_en    (sample_en2),
    .continuous   (continuous2),
    .sensor       (sensor2),
    .base_address (base_address2),
    .slot         (slot2),
    .busy         (busy2),
    .frame_done   (frame_done2)
  );

  task automatic tick();
    @(posedge clk_division);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Latch edge: after this, the DUT sits in frame cycle 0.
  task automatic start();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  // Walks a full default frame checking every cycle. kind 1: change ch0 to
  // 0x20 at poke_k; kind 2: pulse sample_en and scramble inputs at poke_k.
  task automatic frame(input int p0, input int p1, input int poke_k, input int kind);
    for (int k = 0; k < 4096; k++) begin
      chk("slot", k, slot, (k == p0) || (k == p1));
      chk("busy", k, busy, 1'b1);
      chk("frame_done", k, frame_done, k == 4095);
      if (k == poke_k && kind == 1) sensor[7:0] = 8'h20;
      if (k == poke_k && kind == 2) begin
        sample_en    = 1'b1;
        sensor       = 16'hAAAA;
        base_address = 4'h9;
      end
      tick();
      sample_en = 1'b0;
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, -1, busy, 1'b0);
    chk({tag, "_slot"}, -1, slot, 1'b0);
    chk({tag, "_frame_done"}, -1, frame_done, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    sample_en     = 1'b0;
    continuous    = 1'b0;
    sensor        = '0;
    base_address  = '0;
    sample_en2    = 1'b0;
    continuous2   = 1'b0;
    sensor2       = '0;
    base_address2 = '0;
    tick();
    tick();
    idle_chk("reset");
    chk("reset_busy2", -1, busy2, 1'b0);
    chk("reset_slot2", -1, slot2, 1'b0);
    rst = 1'b0;
    tick();
    idle_chk("post_reset");

    // base=5, ch0=0x03 -> 3*16+5=53; ch1=0xFF -> 255*16+6=4086
    sensor       = {8'hFF, 8'h03};
    base_address = 4'd5;
    start();
    frame(53, 4086, -1, 0);
    idle_chk("single_end");
    tick();
    idle_chk("single_idle");

    // base=15, both 0 -> ch0 slot 15 (k=15), ch1 wraps to slot 0 (k=0)
    sensor       = 16'h0000;
    base_address = 4'd15;
    start();
    frame(15, 0, -1, 0);
    idle_chk("wrap_end");

    // continuous: ch0=0x10 -> 261, ch1=0x80 -> 2054; ch0 becomes 0x20 -> 517
    sensor       = {8'h80, 8'h10};
    base_address = 4'd5;
    continuous   = 1'b1;
    start();
    frame(261, 2054, 1000, 1);
    continuous = 1'b0;
    frame(517, 2054, -1, 0);
    idle_chk("cont_end");

    // sample_en mid-frame is ignored along with input changes
    sensor       = {8'hFF, 8'h03};
    base_address = 4'd5;
    start();
    frame(53, 4086, 500, 2);
    idle_chk("restart_end");

    // async reset at k=100 while ch0 (6*16+4) is pulsing
    sensor       = {8'h00, 8'h06};
    base_address = 4'd4;
    start();
    for (int k = 0; k < 100; k++) tick();
    chk("pre_rst_slot", 100, slot, 1'b1);
    chk("pre_rst_busy", 100, busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    idle_chk("async_rst");
    tick();
    idle_chk("held_rst");
    rst = 1'b0;
    tick();
    idle_chk("after_rst");
    sensor       = {8'hFF, 8'h03};
    base_address = 4'd5;
    start();
    frame(53, 4086, -1, 0);
    idle_chk("fresh_end");

    // small config: base=2, values {7,0,3,5} -> k=30,3,12,21, F=32
    sensor2       = {3'd5, 3'd3, 3'd0, 3'd7};
    base_address2 = 2'd2;
    sample_en2    = 1'b1;
    tick();
    sample_en2 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk("small_slot", k, slot2, (k == 30) || (k == 3) || (k == 12) || (k == 21));
      chk("small_busy", k, busy2, 1'b1);
      chk("small_frame_done", k, frame_done2, k == 31);
      tick();
    end
    chk("small_end_busy", 32, busy2, 1'b0);
    chk("small_end_slot", 32, slot2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
